lms_fifo_ctrl: RTL and testbench

Single-clock synchronous FIFO controller for the LMS sample FIFO. It owns the write/read pointers, status flags and fill level. It drives the address and write-enable ports of the distributed simple-dual-port RAM directly downstream of it; that RAM is instantiated next to this block with both RAM clocks tied to clk. Read data is taken straight from the RAM; this block only qualifies it with rd_valid.

---
 rtl/lms_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_lms_fifo_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lms_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, flags and fill level for the LMS sample FIFO's SDP RAM.
// Define LMS_FIFO_CTRL_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module lms_fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned RAM_OUT_REG = 0,
   parameter int unsigned AF_LEVEL    = 2**ADDR_WIDTH - 2,
   parameter int unsigned AE_LEVEL    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   water_level
`ifdef LMS_FIFO_CTRL_ERR_FLAG_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_LEVEL);

   // Illegal thresholds are reported at elaboration, before any clock runs.
   if (AF_LEVEL == 0 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_param_err
      $error("lms_fifo_ctrl: illegal AF_LEVEL/AE_LEVEL for DEPTH");
   end

   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic [ADDR_WIDTH:0] count;
   logic                wr_acc;
   logic                rd_acc;

   always_comb begin
      count        = wr_ptr - rd_ptr;
      full         = (count == DEPTH_L);
      empty        = (count == '0);
      almost_full  = (count >= AF_L);
      almost_empty = (count <= AE_L);
      water_level  = count;
      wr_acc       = wr_en & ~full;
      rd_acc       = rd_en & ~empty;
      ram_wr_en    = wr_acc & ~clr;
      ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
      ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // rd_valid tracks the RAM read latency: same cycle, or one cycle after the pop.
   if (RAM_OUT_REG != 0) begin : g_rd_reg
      logic rd_valid_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rd_valid_q <= 1'b0;
         else        rd_valid_q <= rd_acc & ~clr;
      end
      assign rd_valid = rd_valid_q;
   end else begin : g_rd_comb
      assign rd_valid = rd_acc & ~clr;
   end

`ifdef LMS_FIFO_CTRL_ERR_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & full)  overflow  <= 1'b1;
         if (rd_en & empty) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_lms_fifo_ctrl.sv
// Randomised self-checking bench for lms_fifo_ctrl; checks both RAM read-latency builds
// against a queue-based FIFO model driving small behavioural RAMs.
module tb_lms_fifo_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic clr, wr_en, rd_en;
   logic [7:0] wdata;

   logic       wen0, rv0, full0, empty0, af0, ae0;
   logic [3:0] wa0, ra0;
   logic [4:0] wl0;
   logic       wen1, rv1, full1, empty1, af1, ae1;
   logic [3:0] wa1, ra1;
   logic [4:0] wl1;

   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   logic [7:0] rdq1;

   int unsigned checks = 0;
   int unsigned failures = 0;

   byte unsigned q[$];
   int unsigned  wtot, rtot;
   bit           pend_valid;
   byte unsigned pend_data;

   always #5 clk = ~clk;

   lms_fifo_ctrl #(.ADDR_WIDTH(4), .RAM_OUT_REG(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
      .ram_wr_en(wen0), .ram_wr_addr(wa0), .ram_rd_addr(ra0), .rd_valid(rv0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .water_level(wl0));

   lms_fifo_ctrl #(.ADDR_WIDTH(4), .RAM_OUT_REG(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
      .ram_wr_en(wen1), .ram_wr_addr(wa1), .ram_rd_addr(ra1), .rd_valid(rv1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .water_level(wl1));

   always @(posedge clk) begin
      if (wen0) mem0[wa0] <= wdata;
      if (wen1) mem1[wa1] <= wdata;
      rdq1 <= mem1[ra1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      wtot = 0;
      rtot = 0;
      pend_valid = 1'b0;
   endtask

   task automatic check_status(input string who, input logic [4:0] wl, input logic f,
                               input logic e, input logic af, input logic ae,
                               input logic [3:0] wa, input logic [3:0] ra);
      int unsigned n;
      n = q.size();
      check({who, ".water_level"}, 32'(wl), n);
      check({who, ".full"},  32'(f),  32'(n == 16));
      check({who, ".empty"}, 32'(e),  32'(n == 0));
      check({who, ".almost_full"},  32'(af), 32'(n >= 14));
      check({who, ".almost_empty"}, 32'(ae), 32'(n <= 2));
      check({who, ".wr_addr"}, 32'(wa), wtot % 16);
      check({who, ".rd_addr"}, 32'(ra), rtot % 16);
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, advance the model at posedge.
   task automatic step(input bit w, input bit r, input bit c);
      int unsigned n;
      bit wacc, racc;
      byte unsigned d;
      d = 8'($urandom);
      wr_en = w; rd_en = r; clr = c; wdata = d;
      #1;
      n = q.size();
      wacc = w && (n < 16);
      racc = r && (n > 0);
      check_status("d0", wl0, full0, empty0, af0, ae0, wa0, ra0);
      check_status("d1", wl1, full1, empty1, af1, ae1, wa1, ra1);
      check("d0.ram_wr_en", 32'(wen0), 32'(wacc && !c));
      check("d1.ram_wr_en", 32'(wen1), 32'(wacc && !c));
      check("d0.rd_valid", 32'(rv0), 32'(racc && !c));
      if (racc && !c) check("d0.rd_data", 32'(mem0[ra0]), 32'(q[0]));
      check("d1.rd_valid", 32'(rv1), 32'(pend_valid));
      if (pend_valid) check("d1.rd_data", 32'(rdq1), 32'(pend_data));
      @(posedge clk);
      if (c) begin
         model_reset();
      end else begin
         pend_valid = racc;
         if (racc) begin
            pend_data = q.pop_front();
            rtot++;
         end
         if (wacc) begin
            q.push_back(d);
            wtot++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // reset state, then fill to full and one rejected write
      repeat (2) step(0, 0, 0);
      repeat (16) step(1, 0, 0);
      step(1, 0, 0);
      // full with both requests, then drain and empty with both requests
      step(1, 1, 0);
      step(1, 0, 0);
      repeat (15) step(0, 1, 0);
      step(0, 0, 0);
      repeat (2) step(0, 1, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);

      // steady level 5 across pointer wrap
      repeat (5) step(1, 0, 0);
      repeat (40) step(1, 1, 0);
      repeat (6) step(0, 1, 0);

      // randomised traffic with varying write/read bias and occasional flush
      for (int ph = 0; ph < 4; ph++) begin
         int unsigned pw, pr;
         pw = (ph % 2 == 0) ? 75 : 30;
         pr = (ph % 2 == 0) ? 30 : 75;
         repeat (150) begin
            step($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom_range(99) < 2);
         end
      end

      // flush with 9 entries held and both requests active
      step(0, 0, 1);
      repeat (9) step(1, 0, 0);
      step(1, 1, 1);
      step(0, 1, 0);
      step(1, 0, 0);
      step(0, 1, 0);

      // asynchronous reset mid-stream
      repeat (6) step(1, 0, 0);
      wr_en = 1'b1; rd_en = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      model_reset();
      check_status("d0.rst", wl0, full0, empty0, af0, ae0, wa0, ra0);
      check_status("d1.rst", wl1, full1, empty1, af1, ae1, wa1, ra1);
      check("d0.rst.rd_valid", 32'(rv0), 32'd0);
      check("d1.rst.rd_valid", 32'(rv1), 32'd0);
      check("d0.rst.ram_wr_en", 32'(wen0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(0, 0, 0);
      repeat (60) step($urandom_range(1) == 1, $urandom_range(1) == 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
